// File: rtl/rr_resource_arbiter.sv
// ============================================================================
// Module   : rr_resource_arbiter
// Function : Round-robin owner arbiter with hold timeout and one-cycle gap
//            between successive owners of a shared resource.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_resource_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic           preempt
);

    localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic           gnt_valid_q, gnt_valid_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic           preempt_q, preempt_d;

    logic [IDW-1:0] sel_hi, sel_lo, sel_id;
    logic           found_hi, found_lo;
    logic [IDW-1:0] next_ptr;
    logic           owner_req;
    logic           timeout;

    // Lowest index at or above ptr wins; otherwise wrap to the lowest below ptr.
    always_comb begin
        sel_hi   = '0;
        sel_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (IDW'(i) >= ptr_q)) begin
                sel_hi   = IDW'(i);
                found_hi = 1'b1;
            end
            if (req[i] && (IDW'(i) < ptr_q)) begin
                sel_lo   = IDW'(i);
                found_lo = 1'b1;
            end
        end
        sel_id = found_hi ? sel_hi : sel_lo;
    end

    assign owner_req = |(req & gnt_q);
    assign next_ptr  = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + IDW'(1);

    generate
        if (MAX_HOLD > 0) begin : g_timeout
            assign timeout = (hold_cnt_q == HCW'(MAX_HOLD));
        end else begin : g_no_timeout
            logic unused_hold_cnt;
            assign unused_hold_cnt = ^hold_cnt_q;
            assign timeout         = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        preempt_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (found_hi || found_lo) begin
                    gnt_d      = N'(1) << sel_id;
                    gnt_id_d   = sel_id;
                    hold_cnt_d = HCW'(1);
                    state_d    = ST_BUSY;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!owner_req || timeout) begin
                    // Owner still requesting here means the timeout forced it off.
                    gnt_d     = '0;
                    ptr_d     = next_ptr;
                    preempt_d = owner_req;
                    state_d   = ST_GAP;
                end else if (hold_cnt_q != {HCW{1'b1}}) begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        gnt_valid_d = |gnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            preempt_q   <= preempt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign preempt   = preempt_q;

endmodule

`default_nettype wire
